// File: rtl/rx_capture_pkg.sv
// Shared types and defaults for the rx capture buffer: FSM states, widths, I/Q packing.
package rx_capture_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 8;

   // Packed word layout: 1 puts I in the upper half of {I, Q}.
   localparam bit IQ_I_UPPER = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_PREFETCH,
      ST_READOUT
   } state_t;

endpackage

// File: rtl/rx_capture_ram.sv
// Simple dual-port sample store: one write port, one synchronous read port (1-cycle latency).
module rx_capture_ram #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [2**ADDR_W];
   logic [WIDTH-1:0] rd_data_q;

   // No reset on the array or read register so the store maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/rx_capture_buffer.sv
// Captures I/Q pairs inside the rx window after an arm request, then streams them out
// over a valid/ready port with one word per cycle of throughput.
module rx_capture_buffer
   import rx_capture_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic [7:0]        record_len,
   input  logic              rx,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] data_in_i,
   input  logic [DATA_W-1:0] data_in_q,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [2*DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              busy,
   output logic              done,
   output logic              short_rec,
   output state_t            dbg_state
);

   // Read port: rd_data/rd_last are meaningful while rd_valid=1; a word transfers on the
   // rising clk where rd_valid && rd_ready; with rd_ready=0 the word is held unchanged.

   state_t      state_q, state_d;
   logic [7:0]  len_r_q, len_r_d;
   logic [8:0]  count_q, count_d;
   logic [8:0]  rd_ptr_q, rd_ptr_d;
   logic        rx_d_q;
   logic        short_rec_q, short_rec_d;
   logic        done_q, done_d;
   logic        rd_valid_q, rd_valid_d;
   logic        rd_last_q, rd_last_d;

   logic              wr_en, rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [8:0]        count_inc, rd_ptr_inc, len_ext;
   logic              rx_rise, hs;
   logic [2*DATA_W-1:0] wr_data, ram_rdata;

   assign wr_data = IQ_I_UPPER ? {data_in_i, data_in_q} : {data_in_q, data_in_i};

   always_comb begin
      state_d     = state_q;
      len_r_d     = len_r_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      short_rec_d = short_rec_q;
      done_d      = 1'b0;
      rd_valid_d  = rd_valid_q;
      rd_last_d   = rd_last_q;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      rd_addr     = '0;
      len_ext     = {1'b0, len_r_q};
      count_inc   = count_q + 9'd1;
      rd_ptr_inc  = rd_ptr_q + 9'd1;
      rx_rise     = rx & ~rx_d_q;
      hs          = rd_valid_q & rd_ready;

      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               len_r_d     = record_len;
               short_rec_d = 1'b0;
               count_d     = '0;
               if (record_len == 8'd0) done_d = 1'b1;
               else                    state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            // The edge cycle's own sample belongs to the record.
            if (rx_rise) begin
               state_d = ST_CAPTURE;
               if (sample_valid) begin
                  wr_en   = 1'b1;
                  count_d = count_inc;
                  if (count_inc == len_ext) state_d = ST_PREFETCH;
               end
            end
         end
         ST_CAPTURE: begin
            if (rx) begin
               if (sample_valid) begin
                  wr_en   = 1'b1;
                  count_d = count_inc;
                  if (count_inc == len_ext) state_d = ST_PREFETCH;
               end
            end else if (count_q == 9'd0) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               short_rec_d = 1'b1;
               state_d     = ST_PREFETCH;
            end
         end
         ST_PREFETCH: begin
            rd_en      = 1'b1;
            rd_ptr_d   = '0;
            rd_valid_d = 1'b1;
            rd_last_d  = (count_q == 9'd1);
            state_d    = ST_READOUT;
         end
         ST_READOUT: begin
            if (hs) begin
               if (rd_last_q) begin
                  rd_valid_d = 1'b0;
                  rd_last_d  = 1'b0;
                  done_d     = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  // Lookahead read keeps one word per cycle under continuous rd_ready.
                  rd_en     = 1'b1;
                  rd_addr   = rd_ptr_inc[ADDR_W-1:0];
                  rd_ptr_d  = rd_ptr_inc;
                  rd_last_d = (rd_ptr_q + 9'd2 == count_q);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         len_r_q     <= '0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         rx_d_q      <= 1'b0;
         short_rec_q <= 1'b0;
         done_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_r_q     <= len_r_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         rx_d_q      <= rx;
         short_rec_q <= short_rec_d;
         done_q      <= done_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
      end
   end

   rx_capture_ram #(
      .WIDTH  (2*DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (count_q[ADDR_W-1:0]),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ram_rdata)
   );

   // RAM output is not reset, so mask it to keep rd_data at zero when nothing is offered.
   assign rd_data   = rd_valid_q ? ram_rdata : '0;
   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign short_rec = short_rec_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_rx_capture_buffer.sv
// Bench for rx_capture_buffer: table-driven records, hand-written corner sequences and
// randomized records checked against an array-based model of the capture rules.
module tb_rx_capture_buffer;
   import rx_capture_pkg::*;

   localparam int DATA_W = 16;

   logic              clk;
   logic              rst_n;
   logic              arm;
   logic [7:0]        record_len;
   logic              rx;
   logic              sample_valid;
   logic [DATA_W-1:0] data_in_i;
   logic [DATA_W-1:0] data_in_q;
   logic              rd_valid;
   logic              rd_ready;
   logic [2*DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              busy;
   logic              done;
   logic              short_rec;
   state_t            dbg_state;

   rx_capture_buffer #(.DATA_W(DATA_W), .ADDR_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .arm          (arm),
      .record_len   (record_len),
      .rx           (rx),
      .sample_valid (sample_valid),
      .data_in_i    (data_in_i),
      .data_in_q    (data_in_q),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_data      (rd_data),
      .rd_last      (rd_last),
      .busy         (busy),
      .done         (done),
      .short_rec    (short_rec),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int failures = 0;
   logic [2*DATA_W-1:0] exp_q[$];
   int  done_cnt = 0;
   int  words_seen = 0;
   bit  valid_seen = 0;
   int  rdy_idx = 0;
   bit  stall_prev = 0;
   bit  last_hs_prev = 0;
   logic [2*DATA_W-1:0] held_data;
   logic held_last;
   logic [2*DATA_W-1:0] mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor samples mid-cycle; inputs change at posedge+1, outputs at posedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev   = 0;
         last_hs_prev = 0;
      end else begin
         if (done) done_cnt++;
         if (rd_valid) valid_seen = 1;
         if (last_hs_prev) begin
            chk("done_after_last", 64'(done), 64'd1);
            chk("valid_drop_after_last", 64'(rd_valid), 64'd0);
         end
         if (stall_prev && rd_valid) begin
            chk("stall_data", 64'(rd_data), 64'(held_data));
            chk("stall_last", 64'(rd_last), 64'(held_last));
         end
         last_hs_prev = 0;
         stall_prev   = 0;
         if (rd_valid && rd_ready) begin
            words_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(rd_data), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rd_data", 64'(rd_data), 64'(mon_e));
               chk("rd_last", 64'(rd_last), 64'(exp_q.size() == 0));
            end
            if (rd_last) last_hs_prev = 1;
         end else if (rd_valid) begin
            stall_prev = 1;
            held_data  = rd_data;
            held_last  = rd_last;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_ready(input int mode);
      case (mode)
         0:       rd_ready = 1'b1;
         1:       rd_ready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
         default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      rdy_idx++;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
      chk({tag, "_rd_last"}, 64'(rd_last), 64'd0);
      chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_short_rec"}, 64'(short_rec), 64'd0);
      chk({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
   endtask

   // One record: rx high for pre_hi cycles from the arm cycle, low for gap, high for win,
   // then low. exp_words/exp_short < 0 take the model's answer; abort_at >= 0 resets
   // the DUT after that many words have been read.
   task automatic run_record(input int len, input int pre_hi, input int gap, input int win,
                             input bit rand_valid, input bit noise, input int rmode,
                             input int exp_words, input int exp_short, input int abort_at);
      logic                rx_p[$];
      logic                sv_p[$];
      logic [2*DATA_W-1:0] d_p[$];
      logic [15:0]         n16 = '0;
      int                  edge_k = -1;
      int                  got = 0;
      int                  done_before;
      int                  waited = 0;
      logic                sv;

      for (int j = 0; j < pre_hi; j++) rx_p.push_back(1'b1);
      for (int j = 0; j < gap; j++)    rx_p.push_back(1'b0);
      for (int j = 0; j < win; j++)    rx_p.push_back(1'b1);
      for (int j = 0; j < 3; j++)      rx_p.push_back(1'b0);
      for (int j = 0; j < rx_p.size(); j++) begin
         sv = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         sv_p.push_back(sv);
         if (rand_valid) begin
            d_p.push_back($urandom);
         end else if (j >= pre_hi + gap && j < pre_hi + gap + win) begin
            d_p.push_back({n16, ~n16});
            n16 = n16 + 16'd1;
         end else begin
            d_p.push_back(32'hDEAD_BEEF);
         end
      end

      // Model: first rising edge after the arm cycle, then valid samples while rx stays high.
      for (int k = 1; k < rx_p.size(); k++) begin
         if (rx_p[k] && !rx_p[k-1]) begin
            edge_k = k;
            break;
         end
      end
      exp_q.delete();
      if (edge_k >= 0) begin
         for (int j = edge_k; j < rx_p.size() && rx_p[j] && got < len; j++) begin
            if (sv_p[j]) begin
               exp_q.push_back(d_p[j]);
               got++;
            end
         end
      end

      words_seen  = 0;
      valid_seen  = 0;
      done_before = done_cnt;
      repeat (2) begin
         @(posedge clk); #1;
         arm = 1'b0; sample_valid = 1'b0; rd_ready = 1'b0;
         rx  = (pre_hi > 1);
      end
      for (int j = 0; j < rx_p.size(); j++) begin
         @(posedge clk); #1;
         arm          = (j == 0) || (noise && !rand_valid && $urandom_range(0, 3) == 0);
         record_len   = (j == 0) ? 8'(len) : 8'($urandom_range(0, 255));
         rx           = rx_p[j];
         sample_valid = sv_p[j];
         data_in_i    = d_p[j][31:16];
         data_in_q    = d_p[j][15:0];
         rd_ready     = 1'b0;
      end
      @(posedge clk); #1;
      arm = 1'b0; sample_valid = 1'b0; rx = 1'b0;

      rdy_idx = 0;
      while (done_cnt == done_before && waited < 3000) begin
         if (abort_at >= 0 && words_seen >= abort_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("abort");
            chk("abort_words", 64'(words_seen), 64'(abort_at));
            exp_q.delete();
            rd_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("abort_no_done", 64'(done_cnt - done_before), 64'd0);
            return;
         end
         drive_ready(rmode);
         @(posedge clk); #1;
         waited++;
      end
      if (done_cnt == done_before) chk("done_timeout", 64'd0, 64'd1);
      rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("done_count", 64'(done_cnt - done_before), 64'd1);
      chk("word_count", 64'(words_seen), 64'(exp_words >= 0 ? exp_words : got));
      chk("words_left", 64'(exp_q.size()), 64'd0);
      if (got > 0)
         chk("short_rec", 64'(short_rec), 64'(exp_short >= 0 ? exp_short : int'(got < len)));
      else
         chk("empty_no_valid", 64'(valid_seen), 64'd0);
      chk("busy_end", 64'(busy), 64'd0);
      chk("rd_valid_end", 64'(rd_valid), 64'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int len;
      int pre_hi;
      int gap;
      int win;
      bit rand_valid;
      bit noise;
      int rmode;
      int exp_words;
      int exp_short;
   } vec_t;

   vec_t vecs[9];
   int   db;

   initial begin
      // full record with arm pulses during capture, early fall, back-pressure with exact
      // fill, rx already high at arm, single word, full depth, one short, arm on the edge
      // cycle, short record left behind for the next arm to clear
      vecs[0] = '{100, 0, 2, 150, 1'b0, 1'b1, 0, 100, 0};
      vecs[1] = '{100, 0, 2, 40,  1'b0, 1'b0, 0, 40,  1};
      vecs[2] = '{10,  0, 1, 10,  1'b0, 1'b0, 1, 10,  0};
      vecs[3] = '{5,   20, 3, 20, 1'b0, 1'b0, 0, 5,   0};
      vecs[4] = '{1,   0, 1, 5,   1'b0, 1'b0, 0, 1,   0};
      vecs[5] = '{255, 0, 1, 255, 1'b0, 1'b1, 2, 255, 0};
      vecs[6] = '{8,   0, 1, 7,   1'b0, 1'b0, 1, 7,   1};
      vecs[7] = '{4,   1, 2, 6,   1'b0, 1'b0, 0, 4,   0};
      vecs[8] = '{6,   0, 1, 3,   1'b0, 1'b0, 0, 3,   1};

      rst_n = 1'b1; arm = 1'b0; record_len = '0; rx = 1'b0; sample_valid = 1'b0;
      data_in_i = '0; data_in_q = '0; rd_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int v = 0; v < 9; v++)
         run_record(vecs[v].len, vecs[v].pre_hi, vecs[v].gap, vecs[v].win, vecs[v].rand_valid,
                    vecs[v].noise, vecs[v].rmode, vecs[v].exp_words, vecs[v].exp_short, -1);

      // record_len = 0: done the cycle after arm, no readout, arm clears sticky short_rec
      chk("short_before_len0", 64'(short_rec), 64'd1);
      db = done_cnt;
      valid_seen = 0;
      @(posedge clk); #1;
      arm = 1'b1; record_len = 8'd0;
      @(posedge clk); #1;
      arm = 1'b0; record_len = 8'd77;
      chk("len0_done", 64'(done), 64'd1);
      chk("len0_busy", 64'(busy), 64'd0);
      chk("len0_short_cleared", 64'(short_rec), 64'd0);
      @(posedge clk); #1;
      chk("len0_done_pulse", 64'(done), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("len0_done_count", 64'(done_cnt - db), 64'd1);
      chk("len0_no_valid", 64'(valid_seen), 64'd0);

      // reset part-way through readout, then a fresh record must work
      run_record(20, 0, 1, 10, 1'b0, 1'b0, 0, 10, 1, 3);
      run_record(4, 0, 2, 8, 1'b0, 1'b0, 0, 4, 0, -1);

      // randomized records against the model
      for (int r = 0; r < 14; r++) begin
         if (r % 3 == 0)
            run_record($urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(1, 4),
                       $urandom_range(1, 50), 1'b0, 1'b1, 2, -1, -1, -1);
         else
            run_record($urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(1, 4),
                       $urandom_range(1, 50), 1'b1, 1'b0, 2, -1, -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
